// File: rtl/pp_in_pkg.sv
// Shared constants for the parallel input capture port.
// Latency: n/a (declarations only).
// Backpressure: n/a (the bus has no wait states).
package pp_in_pkg;

  // readdata appears one cycle after the read strobe
  localparam int READ_LATENCY = 1;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_CAPTURE  = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;

endpackage

// File: rtl/pp_in_capture_if.sv
// Avalon-MM slave bus bundle for the parallel input capture port.
// Latency: reads return one cycle after the strobe; writes land on the strobe edge.
// Backpressure: none; no waitrequest, every access completes at once.
interface pp_in_capture_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );

endinterface

// File: rtl/pp_in_debounce.sv
// Two-flop synchroniser, sample-tick prescaler and two-sample debounce per pin.
// Latency: pin change reaches deb after 4 edges when the divider is 0.
// Backpressure: none; free-running every cycle.
module pp_in_debounce #(
  parameter int WIDTH    = 8,
  parameter int DEB_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    pp_in,
  input  logic [DEB_BITS-1:0] div_n,
  input  logic                div_reload,
  output logic [WIDTH-1:0]    deb,
  output logic [WIDTH-1:0]    deb_upd_mask
);

  logic [WIDTH-1:0]    sync1_q, sync1_d;
  logic [WIDTH-1:0]    sync2_q, sync2_d;
  logic [WIDTH-1:0]    samp_q,  samp_d;
  logic [WIDTH-1:0]    deb_q,   deb_d;
  logic [DEB_BITS-1:0] cnt_q,   cnt_d;
  logic                tick;
  logic [WIDTH-1:0]    upd;

  // Prescaler tick, sync chain shift and debounce decision
  always_comb begin
    sync1_d = pp_in;
    sync2_d = sync1_q;

    // A divider write restarts the count and swallows that cycle's tick,
    // so the new period always starts cleanly from zero.
    tick = (cnt_q == div_n) && !div_reload;
    if (div_reload || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DEB_BITS'(1);
    end

    // A bit moves only when two consecutive ticks saw the same level and
    // that level differs from what is currently published.
    upd = '0;
    if (tick) begin
      upd = ~(sync2_q ^ samp_q) & (sync2_q ^ deb_q);
    end

    samp_d = tick ? sync2_q : samp_q;
    deb_d  = deb_q ^ upd;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb          = deb_q;
  assign deb_upd_mask = upd;

endmodule

// File: rtl/pp_in_capture.sv
// Avalon-MM parallel input port: debounced DATA, W1C edge CAPTURE, masked level irq.
// Latency: readdata one cycle after read; edge to CAPTURE on the deb-update edge.
// Backpressure: none; zero wait states, accesses always complete.
module pp_in_capture
  import pp_in_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEB_DEFAULT = 0,
  parameter int DEB_BITS    = 16
) (
  input  logic             clk,
  input  logic             reset,
  pp_in_capture_if.slave   bus,
  output logic             irq,
  input  logic [WIDTH-1:0] pp_in
);

  logic [WIDTH-1:0]    cap_q,  cap_d;
  logic [WIDTH-1:0]    mask_q, mask_d;
  logic [WIDTH-1:0]    rise_q, rise_d;
  logic [WIDTH-1:0]    fall_q, fall_d;
  logic [DEB_BITS-1:0] div_q,  div_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q,  irq_d;

  logic                wr_en;
  logic                rd_en;
  logic                div_wr;
  logic [WIDTH-1:0]    wdat;
  logic [WIDTH-1:0]    w1c;
  logic [WIDTH-1:0]    rise_evt;
  logic [WIDTH-1:0]    fall_evt;
  logic [31:0]         rd_val;
  logic [WIDTH-1:0]    deb;
  logic [WIDTH-1:0]    deb_upd;
  logic                unused_wdat;

  // Bits of writedata above WIDTH/DEB_BITS are intentionally dropped
  assign unused_wdat = ^bus.writedata;

  pp_in_debounce #(
    .WIDTH    (WIDTH),
    .DEB_BITS (DEB_BITS)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .pp_in        (pp_in),
    .div_n        (div_q),
    .div_reload   (div_wr),
    .deb          (deb),
    .deb_upd_mask (deb_upd)
  );

  // Register writes, edge capture and next irq level
  always_comb begin
    wr_en  = bus.chipselect && bus.write;
    rd_en  = bus.chipselect && bus.read;
    wdat   = bus.writedata[WIDTH-1:0];
    div_wr = wr_en && (bus.address == ADDR_DEBOUNCE);

    w1c = '0;
    if (wr_en && (bus.address == ADDR_CAPTURE)) begin
      w1c = wdat;
    end

    // deb_upd marks exactly the bits that flip this edge, so the old deb
    // value alone tells the direction.
    rise_evt = deb_upd & ~deb & rise_q;
    fall_evt = deb_upd &  deb & fall_q;

    // Sets are OR-ed after the clear so a coincident edge is never lost
    cap_d = (cap_q & ~w1c) | rise_evt | fall_evt;

    mask_d = mask_q;
    rise_d = rise_q;
    fall_d = fall_q;
    if (wr_en && (bus.address == ADDR_MASK))    mask_d = wdat;
    if (wr_en && (bus.address == ADDR_RISE_EN)) rise_d = wdat;
    if (wr_en && (bus.address == ADDR_FALL_EN)) fall_d = wdat;
    div_d = div_wr ? bus.writedata[DEB_BITS-1:0] : div_q;

    irq_d = |(cap_d & mask_d);
  end

  // Read mux on current (pre-write) register values, held between reads
  always_comb begin
    rd_val = '0;
    case (bus.address)
      ADDR_DATA:     rd_val = 32'(deb);
      ADDR_CAPTURE:  rd_val = 32'(cap_q);
      ADDR_MASK:     rd_val = 32'(mask_q);
      ADDR_RISE_EN:  rd_val = 32'(rise_q);
      ADDR_FALL_EN:  rd_val = 32'(fall_q);
      ADDR_DEBOUNCE: rd_val = 32'(div_q);
      default:       rd_val = '0;
    endcase
    readdata_d = rd_en ? rd_val : readdata_q;
  end

  // Register file, readdata and irq flops with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q      <= '0;
      mask_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      div_q      <= DEB_BITS'(DEB_DEFAULT);
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      div_q      <= div_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
